// File: rtl/load_store_unit.sv
// Memory-access stage: one load/store per req/ack transaction with byte enables, lane replication, load extension.
// Latency: accept + >=1 REQ cycle + 1 DONE cycle. Backpressure: req_ready low and stall high while in flight.
module load_store_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] ALUResult,
    input  logic [DATA_WIDTH-1:0] StoreData,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            Funct3,
    input  logic                  req_valid,
    output logic                  req_ready,
    output logic                  stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_be,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rd_q;
    logic [3:0]            be_q;
    logic [1:0]            off_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic                  we_q;
    logic                  err_q;
    logic [CW-1:0]         cnt_q;

    logic [1:0]            off;
    logic                  f3_ok;
    logic                  misalign;
    logic                  illegal;
    logic                  attempt;
    logic                  accept;
    logic [3:0]            be_n;
    logic [DATA_WIDTH-1:0] wdata_n;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] load_val;
    logic                  timeout;

    assign off = ALUResult[1:0];

    // Legality and store lane encoding are decided from the raw EX inputs in the accept cycle.
    always_comb begin
        f3_ok    = 1'b0;
        misalign = 1'b0;
        be_n     = 4'hF;
        wdata_n  = StoreData;
        case (Funct3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = MemRead && !MemWrite;
            default:                f3_ok = 1'b0;
        endcase
        case (Funct3[1:0])
            2'b01:   misalign = off[0];
            2'b10:   misalign = |off;
            default: misalign = 1'b0;
        endcase
        if (MemWrite) begin
            case (Funct3[1:0])
                2'b00: begin
                    be_n    = 4'b0001 << off;
                    wdata_n = {4{StoreData[7:0]}};
                end
                2'b01: begin
                    be_n    = 4'b0011 << off;
                    wdata_n = {2{StoreData[15:0]}};
                end
                default: begin
                    be_n    = 4'hF;
                    wdata_n = StoreData;
                end
            endcase
        end
    end

    assign illegal = (MemRead && MemWrite) || !f3_ok || misalign;
    assign attempt = (state_q == IDLE) && req_valid && (MemRead || MemWrite);
    assign accept  = attempt && !illegal;
    assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES));

    always_comb begin
        shifted  = mem_rdata >> {off_q, 3'b000};
        load_val = mem_rdata;
        case (size_q)
            2'b00: load_val = uns_q ? {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]}
                                    : {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
            2'b01: load_val = uns_q ? {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]}
                                    : {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
            default: load_val = mem_rdata;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        stall     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = 4'h0;
        done      = 1'b0;
        rd_data   = rd_q;
        err       = err_q || (attempt && illegal);
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                stall     = accept;
                if (accept) state_d = REQ;
            end
            REQ: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                mem_be    = be_q;
                if (mem_ack)      state_d = DONE;
                else if (timeout) state_d = IDLE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            be_q    <= 4'h0;
            off_q   <= 2'b00;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_q  <= {ALUResult[DATA_WIDTH-1:2], 2'b00};
                        wdata_q <= wdata_n;
                        be_q    <= be_n;
                        off_q   <= off;
                        size_q  <= Funct3[1:0];
                        uns_q   <= Funct3[2];
                        we_q    <= MemWrite;
                        cnt_q   <= '0;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        cnt_q <= '0;
                        rd_q  <= we_q ? '0 : load_val;
                    end else if (timeout) begin
                        // Abandon the request; the error is reported the cycle we are back in IDLE.
                        cnt_q <= '0;
                        err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: rd_q <= '0;
                default: rd_q <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a transaction-level reference model and a per-cycle compare.
module tb_load_store_unit;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] ALUResult = '0;
    logic [31:0] StoreData = '0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [2:0]  Funct3 = 3'b000;
    logic        req_valid = 1'b0;
    logic        req_ready, stall, mem_req, mem_we, done, err;
    logic [31:0] mem_addr, mem_wdata, rd_data;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata = '0;

    logic        auto_ack = 1'b0;
    logic        force_ack = 1'b0;
    assign mem_ack = auto_ack | force_ack;

    int errors = 0;
    int checks = 0;

    load_store_unit #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .ALUResult(ALUResult), .StoreData(StoreData),
        .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3), .req_valid(req_valid),
        .req_ready(req_ready), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .done(done), .rd_data(rd_data), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---- reference rules ----
    function automatic int size_of(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit is_legal(input bit r, input bit w, input logic [2:0] f3, input logic [31:0] a);
        if (r && w) return 0;
        if (w && !(f3 inside {3'd0, 3'd1, 3'd2})) return 0;
        if (r && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 0;
        return (a % size_of(f3)) == 0;
    endfunction

    function automatic logic [3:0] exp_be(input bit w, input logic [2:0] f3, input logic [31:0] a);
        int n;
        if (!w) return 4'hF;
        n = size_of(f3);
        return 4'(((1 << n) - 1) << a[1:0]);
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] sd);
        int n;
        n = size_of(f3);
        if (n == 1) return 32'({24'd0, sd[7:0]} * 32'h0101_0101);
        if (n == 2) return 32'({16'd0, sd[15:0]} * 32'h0001_0001);
        return sd;
    endfunction

    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        int    n;
        longint v;
        n = size_of(f3);
        if (n == 4) return rd;
        v = longint'(rd >> (8 * int'(a[1:0])));
        v = v % (longint'(1) << (8 * n));
        if (!f3[2] && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        return 32'(v);
    endfunction

    // ---- transaction-level model ----
    bit          m_busy = 0, m_done = 0, m_err = 0;
    int          m_wait = 0;
    logic [31:0] m_res = '0;
    logic [31:0] t_addr = '0, t_wdata = '0, t_araw = '0;
    logic [3:0]  t_be = '0;
    logic        t_we = 0;
    logic [2:0]  t_f3 = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy = 0; m_done = 0; m_err = 0; m_wait = 0; m_res = '0;
        end else begin
            m_err = 0;
            if (m_done) begin
                m_done = 0;
                m_res  = '0;
            end else if (m_busy) begin
                if (mem_ack) begin
                    m_busy = 0;
                    m_done = 1;
                    m_res  = t_we ? 32'd0 : extract(t_f3, t_araw, mem_rdata);
                end else begin
                    m_wait++;
                    if (m_wait > TMO) begin
                        m_busy = 0;
                        m_err  = 1;
                    end
                end
            end else if (req_valid && (MemRead || MemWrite) && is_legal(MemRead, MemWrite, Funct3, ALUResult)) begin
                m_busy  = 1;
                m_wait  = 0;
                t_araw  = ALUResult;
                t_addr  = ALUResult & 32'hFFFF_FFFC;
                t_we    = MemWrite;
                t_f3    = Funct3;
                t_be    = exp_be(MemWrite, Funct3, ALUResult);
                t_wdata = exp_wdata(Funct3, StoreData);
            end
        end
    end

    // ---- memory responder ----
    logic [31:0] mem_arr [64];
    bit          ack_en = 1;
    int          ack_delay = 0;
    int          wait_cnt = 0;

    always @(posedge clk) begin
        #2;
        auto_ack = 1'b0;
        if (mem_req && ack_en) begin
            if (wait_cnt == ack_delay) begin
                auto_ack  = 1'b1;
                mem_rdata = mem_arr[mem_addr[7:2]];
                if (mem_we)
                    for (int b = 0; b < 4; b++)
                        if (mem_be[b]) mem_arr[mem_addr[7:2]][8*b +: 8] = mem_wdata[8*b +: 8];
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // ---- per-cycle compare plus observation counters ----
    int          mon_cyc, mon_stall, mon_busy, mon_req, mon_done, mon_done_at, mon_err, mon_err_at;
    logic [31:0] mon_rd, snap_addr, snap_wdata;
    logic [3:0]  snap_be;
    logic        snap_we;

    task automatic mon_clear();
        mon_cyc = 0; mon_stall = 0; mon_busy = 0; mon_req = 0;
        mon_done = 0; mon_done_at = 0; mon_err = 0; mon_err_at = 0;
        mon_rd = '0; snap_addr = '0; snap_wdata = '0; snap_be = '0; snap_we = 0;
    endtask

    always @(negedge clk) begin
        bit idle_m, att, leg;
        idle_m = !m_busy && !m_done;
        att    = idle_m && req_valid && (MemRead || MemWrite);
        leg    = is_legal(MemRead, MemWrite, Funct3, ALUResult);
        chk("req_ready", 32'(req_ready), 32'(idle_m));
        chk("stall", 32'(stall), 32'(m_busy || (att && leg)));
        chk("mem_req", 32'(mem_req), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        chk("err", 32'(err), 32'(m_err || (att && !leg)));
        chk("rd_data", rd_data, m_done ? m_res : 32'd0);
        if (m_busy) begin
            chk("mem_addr", mem_addr, t_addr);
            chk("mem_we", 32'(mem_we), 32'(t_we));
            chk("mem_be", 32'(mem_be), 32'(t_be));
            if (t_we) chk("mem_wdata", mem_wdata, t_wdata);
        end
        mon_cyc++;
        if (stall) mon_stall++;
        if (!req_ready) mon_busy++;
        if (mem_req) begin
            if (mon_req == 0) begin
                snap_addr = mem_addr; snap_wdata = mem_wdata; snap_be = mem_be; snap_we = mem_we;
            end
            mon_req++;
        end
        if (done) begin mon_done++; mon_done_at = mon_cyc; mon_rd = rd_data; end
        if (err)  begin mon_err++;  mon_err_at = mon_cyc; end
    end

    // ---- stimulus ----
    task automatic issue(input bit r, input bit w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd);
        @(posedge clk); #2;
        mon_clear();
        MemRead = r; MemWrite = w; Funct3 = f3; ALUResult = a; StoreData = sd; req_valid = 1'b1;
        @(posedge clk); #2;
        req_valid = 1'b0;
        ALUResult = $urandom; StoreData = $urandom; Funct3 = 3'($urandom);
        MemRead = 1'($urandom); MemWrite = 1'($urandom);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (!m_busy && !m_done && !m_err) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_idle: transaction still open after 40 cycles");
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem_arr[i] = '0;
        mem_arr[0] = 32'h80AA_BBCC;
        mon_clear();

        // Reset values
        @(negedge clk); #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_done_err", {30'd0, done, err}, 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        @(posedge clk); #2;
        reset = 1'b1;

        // LB / LBU at byte 3, ack two cycles after request
        ack_en = 1; ack_delay = 2;
        issue(1, 0, 3'b000, 32'h0000_0003, 32'h0);
        wait_idle();
        chk("lb_addr", snap_addr, 32'h0);
        chk("lb_be", 32'(snap_be), 32'hF);
        chk("lb_done_cnt", mon_done, 1);
        chk("lb_rd", mon_rd, 32'hFFFF_FF80);
        chk("lb_req_cycles", mon_req, 3);
        issue(1, 0, 3'b100, 32'h0000_0003, 32'h0);
        wait_idle();
        chk("lbu_rd", mon_rd, 32'h0000_0080);

        // SH with same-cycle ack
        ack_delay = 0;
        issue(0, 1, 3'b001, 32'h0000_0012, 32'h1234_ABCD);
        wait_idle();
        chk("sh_we", 32'(snap_we), 32'd1);
        chk("sh_addr", snap_addr, 32'h10);
        chk("sh_be", 32'(snap_be), 32'b1100);
        chk("sh_wdata", snap_wdata, 32'hABCD_ABCD);
        chk("sh_stall_cycles", mon_stall, 2);
        chk("sh_done_at", mon_done_at, 3);

        // Illegal accesses are rejected in the accept cycle
        issue(1, 0, 3'b010, 32'h0000_0006, 32'h0);
        wait_idle();
        chk("lw_mis_err", mon_err, 1);
        chk("lw_mis_err_at", mon_err_at, 1);
        chk("lw_mis_req", mon_req, 0);
        chk("lw_mis_stall", mon_stall, 0);
        chk("lw_mis_busy", mon_busy, 0);
        issue(1, 1, 3'b010, 32'h0000_0000, 32'h0);
        wait_idle();
        chk("rw_both_err", mon_err, 1);
        chk("rw_both_req", mon_req, 0);
        issue(0, 1, 3'b100, 32'h0000_0000, 32'h0);
        wait_idle();
        chk("st_f3_err", mon_err, 1);
        issue(0, 0, 3'b010, 32'h0000_0000, 32'h0);
        wait_idle();
        chk("no_op_err", mon_err, 0);
        chk("no_op_stall", mon_stall, 0);

        // Timeout with the acknowledge withheld
        ack_en = 0;
        issue(1, 0, 3'b001, 32'h0000_0020, 32'h0);
        wait_idle();
        chk("tmo_req_cycles", mon_req, TMO + 1);
        chk("tmo_err", mon_err, 1);
        chk("tmo_err_at", mon_err_at, TMO + 3);
        chk("tmo_done", mon_done, 0);

        // Reset while a request is outstanding; a later stray ack is ignored
        issue(1, 0, 3'b010, 32'h0000_0100, 32'h0);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mid_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #2;
        reset = 1'b1;
        mon_clear();
        force_ack = 1'b1;
        @(posedge clk); #2;
        force_ack = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("rst_mid_done", mon_done, 0);
        chk("rst_mid_err", mon_err, 0);
        chk("rst_mid_req", mon_req, 0);

        // Back-to-back SW then LW; LW is held until accepted the cycle after DONE
        ack_en = 1; ack_delay = 0;
        @(posedge clk); #2;
        mon_clear();
        MemRead = 0; MemWrite = 1; Funct3 = 3'b010; ALUResult = 32'h40; StoreData = 32'hDEAD_BEEF;
        req_valid = 1'b1;
        @(posedge clk); #2;
        MemRead = 1; MemWrite = 0; Funct3 = 3'b010; ALUResult = 32'h40; StoreData = 32'h0;
        repeat (3) begin @(posedge clk); #2; end
        req_valid = 1'b0;
        wait_idle();
        chk("b2b_done_cnt", mon_done, 2);
        chk("b2b_done_at", mon_done_at, 6);
        chk("b2b_rd", mon_rd, 32'hDEAD_BEEF);
        chk("b2b_stall", mon_stall, 4);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
